// File: rtl/bullet_controller.sv
// Per-player bullet source: spawns on a fire edge, steps once per frame in the
// direction latched at spawn, retires on hit or screen edge, then cools down.
module bullet_controller #(
  parameter int unsigned X_MAX           = 639,
  parameter int unsigned Y_MAX           = 479,
  parameter int unsigned STEP            = 4,
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter int unsigned SIZE            = 2,
  parameter int unsigned PARK            = 900
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       fire,
  input  logic [9:0] ShooterX,
  input  logic [9:0] ShooterY,
  input  logic [1:0] Direction,
  input  logic       target_hit,
  input  logic       armor_hit,
  input  logic       bullet_on_bullet_hit,
  output logic [9:0] BulletX,
  output logic [9:0] BulletY,
  output logic [9:0] Bullet_Size,
  output logic       bullet_active,
  output logic       shot_fired,
  output logic [1:0] last_retire
);

  typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_e;

  localparam int unsigned CW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [9:0]    PARK_V = 10'(PARK);
  localparam logic [9:0]    STEP_V = 10'(STEP);
  localparam logic [10:0]   STEP11 = 11'(STEP);
  localparam logic [10:0]   XMAX11 = 11'(X_MAX);
  localparam logic [10:0]   YMAX11 = 11'(Y_MAX);
  localparam logic [CW-1:0] CD_V   = CW'(COOLDOWN_FRAMES);
  localparam logic [CW-1:0] CD_ONE = CW'(1);

  localparam logic [1:0] DIR_R = 2'b00, DIR_L = 2'b01, DIR_D = 2'b10;

  state_e        state_q, state_d;
  logic          fire_q;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [1:0]    dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          shot_q, shot_d;
  logic          act_q, act_d;
  logic [1:0]    last_q, last_d;

  logic fire_edge;
  logic oob;

  assign fire_edge = fire & ~fire_q;

  // Edge test looks one step ahead at 11 bits so the sum cannot wrap.
  always_comb begin
    unique case (dir_q)
      DIR_R:   oob = ({1'b0, x_q} + STEP11) > XMAX11;
      DIR_L:   oob = {1'b0, x_q} < STEP11;
      DIR_D:   oob = ({1'b0, y_q} + STEP11) > YMAX11;
      default: oob = {1'b0, y_q} < STEP11;
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    shot_d  = 1'b0;
    act_d   = act_q;
    last_d  = last_q;

    unique case (state_q)
      IDLE: begin
        x_d = PARK_V;
        y_d = PARK_V;
        if (fire_edge) begin
          x_d     = ShooterX;
          y_d     = ShooterY;
          dir_d   = Direction;
          shot_d  = 1'b1;
          act_d   = 1'b1;
          state_d = FLYING;
        end
      end

      FLYING: begin
        if (target_hit || armor_hit || bullet_on_bullet_hit || oob) begin
          if (target_hit)                           last_d = 2'b01;
          else if (armor_hit || bullet_on_bullet_hit) last_d = 2'b10;
          else                                      last_d = 2'b11;
          x_d   = PARK_V;
          y_d   = PARK_V;
          act_d = 1'b0;
          if (COOLDOWN_FRAMES == 0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = CD_V;
            state_d = COOLDOWN;
          end
        end else begin
          unique case (dir_q)
            DIR_R:   x_d = x_q + STEP_V;
            DIR_L:   x_d = x_q - STEP_V;
            DIR_D:   y_d = y_q + STEP_V;
            default: y_d = y_q - STEP_V;
          endcase
        end
      end

      COOLDOWN: begin
        // Fire edges and late hit flags are deliberately ignored here.
        x_d = PARK_V;
        y_d = PARK_V;
        if (cnt_q <= CD_ONE) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CD_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        x_d     = PARK_V;
        y_d     = PARK_V;
        act_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // fire_q resets high so a key held through reset does not shoot.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      fire_q  <= 1'b1;
      x_q     <= PARK_V;
      y_q     <= PARK_V;
      dir_q   <= DIR_R;
      cnt_q   <= '0;
      shot_q  <= 1'b0;
      act_q   <= 1'b0;
      last_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      fire_q  <= fire;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      shot_q  <= shot_d;
      act_q   <= act_d;
      last_q  <= last_d;
    end
  end

  assign BulletX       = x_q;
  assign BulletY       = y_q;
  assign Bullet_Size   = 10'(SIZE);
  assign bullet_active = act_q;
  assign shot_fired    = shot_q;
  assign last_retire   = last_q;

endmodule

// File: tb/tb_bullet_controller.sv
// Bench for bullet_controller: vector table, directed corner sequences, and
// random stimulus against a frame-level behavioural model.
module tb_bullet_controller;

  localparam int X_MAX = 639, Y_MAX = 479, STEP = 4, CD = 30, SIZE = 2, PARK = 900;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fire = 1'b0;
  logic [9:0] sx = '0, sy = '0;
  logic [1:0] dir = '0;
  logic       th = 1'b0, ah = 1'b0, bh = 1'b0;
  logic [9:0] bx, by, bsz;
  logic       act, shot;
  logic [1:0] last;

  logic       fire0 = 1'b0, th0 = 1'b0, ah0 = 1'b0, bh0 = 1'b0;
  logic [9:0] bx0, by0, bsz0;
  logic       act0, shot0;
  logic [1:0] last0;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  bullet_controller dut (
    .frame_clk(clk), .Reset(rst), .fire(fire), .ShooterX(sx), .ShooterY(sy),
    .Direction(dir), .target_hit(th), .armor_hit(ah), .bullet_on_bullet_hit(bh),
    .BulletX(bx), .BulletY(by), .Bullet_Size(bsz), .bullet_active(act),
    .shot_fired(shot), .last_retire(last));

  bullet_controller #(.COOLDOWN_FRAMES(0)) dut0 (
    .frame_clk(clk), .Reset(rst), .fire(fire0), .ShooterX(sx), .ShooterY(sy),
    .Direction(dir), .target_hit(th0), .armor_hit(ah0), .bullet_on_bullet_hit(bh0),
    .BulletX(bx0), .BulletY(by0), .Bullet_Size(bsz0), .bullet_active(act0),
    .shot_fired(shot0), .last_retire(last0));

  // Frame-level model: a bullet is either alive at (m_x,m_y) or parked.
  int m_alive, m_x, m_y, m_dir, m_wait, m_last, m_shot, m_prev_fire;

  task automatic model_reset();
    m_alive = 0; m_x = PARK; m_y = PARK; m_dir = 0;
    m_wait = 0; m_last = 0; m_shot = 0; m_prev_fire = 1;
  endtask

  task automatic model_retire(input int cause);
    m_alive = 0; m_last = cause; m_wait = CD; m_x = PARK; m_y = PARK;
  endtask

  task automatic model_step();
    int nx, ny;
    bit pressed;
    pressed = fire && !m_prev_fire;
    m_shot = 0;
    if (m_alive != 0) begin
      nx = m_x; ny = m_y;
      case (m_dir)
        0: nx = m_x + STEP;
        1: nx = m_x - STEP;
        2: ny = m_y + STEP;
        default: ny = m_y - STEP;
      endcase
      if (th) model_retire(1);
      else if (ah || bh) model_retire(2);
      else if (nx < 0 || nx > X_MAX || ny < 0 || ny > Y_MAX) model_retire(3);
      else begin m_x = nx; m_y = ny; end
    end else if (m_wait > 0) begin
      m_wait = m_wait - 1;
    end else if (pressed) begin
      m_alive = 1; m_x = sx; m_y = sy; m_dir = dir; m_shot = 1;
    end
    m_prev_fire = fire;
  endtask

  task automatic chk(input string nm, input int actual, input int exp);
    checks++;
    if (actual != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, actual, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("BulletX", bx, m_x);
    chk("BulletY", by, m_y);
    chk("active", act, m_alive);
    chk("shot_fired", shot, m_shot);
    chk("last_retire", last, m_last);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk_model();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst BulletX", bx, PARK);
    chk("rst BulletY", by, PARK);
    chk("rst active", act, 0);
    chk("rst shot", shot, 0);
    chk("rst last", last, 0);
    chk("rst0 BulletX", bx0, PARK);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    string      nm;
    logic       f;
    int         x, y;
    logic [1:0] d;
    logic       t, a, b;
    int         ex, ey;
    logic       eact, eshot;
    logic [1:0] elast;
  } vec_t;

  vec_t tbl[6];
  int   shots;

  initial begin
    tbl[0] = '{"spawn 632",    1'b1, 632, 200, 2'b00, 1'b0, 1'b0, 1'b0, 632, 200, 1'b1, 1'b1, 2'b00};
    tbl[1] = '{"step 636",     1'b1, 0,   0,   2'b11, 1'b0, 1'b0, 1'b0, 636, 200, 1'b1, 1'b0, 2'b00};
    tbl[2] = '{"retire edge",  1'b0, 0,   0,   2'b01, 1'b0, 1'b0, 1'b0, PARK, PARK, 1'b0, 1'b0, 2'b11};
    tbl[3] = '{"cd fire",      1'b1, 5,   5,   2'b00, 1'b0, 1'b0, 1'b0, PARK, PARK, 1'b0, 1'b0, 2'b11};
    tbl[4] = '{"cd armor",     1'b0, 5,   5,   2'b00, 1'b0, 1'b1, 1'b0, PARK, PARK, 1'b0, 1'b0, 2'b11};
    tbl[5] = '{"cd target",    1'b0, 5,   5,   2'b00, 1'b1, 1'b0, 1'b0, PARK, PARK, 1'b0, 1'b0, 2'b11};

    // Reset with fire held high: no shot on release.
    fire = 1'b1;
    do_reset();
    chk("Bullet_Size", bsz, SIZE);
    repeat (3) tick();
    chk("held no shot", act, 0);

    // Vector table: right-edge retire then ignored fire edges in cooldown.
    fire = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      fire = tbl[i].f; sx = 10'(tbl[i].x); sy = 10'(tbl[i].y); dir = tbl[i].d;
      th = tbl[i].t; ah = tbl[i].a; bh = tbl[i].b;
      tick();
      chk({tbl[i].nm, " X"}, bx, tbl[i].ex);
      chk({tbl[i].nm, " Y"}, by, tbl[i].ey);
      chk({tbl[i].nm, " act"}, act, tbl[i].eact);
      chk({tbl[i].nm, " shot"}, shot, tbl[i].eshot);
      chk({tbl[i].nm, " last"}, last, tbl[i].elast);
    end
    th = 0; ah = 0; bh = 0;
    for (int i = 0; i < 27; i++) begin
      fire = (i % 2 == 1);
      tick();
      chk("cd still idle", act, 0);
    end
    fire = 1'b1; sx = 10'd50; sy = 10'd60; dir = 2'b00;
    tick();
    chk("spawn after cd", act, 1);
    chk("spawn after cd shot", shot, 1);

    // Held fire for 50 frames: one pulse, steady rightward steps.
    fire = 1'b0;
    do_reset();
    tick();
    fire = 1'b1; sx = 10'd100; sy = 10'd200; dir = 2'b00;
    tick();
    shots = shot;
    for (int i = 1; i <= 50; i++) begin
      sx = 10'($urandom_range(0, 639)); dir = 2'($urandom);
      tick();
      shots += shot;
      chk("held X", bx, 100 + 4 * i);
      chk("held Y", by, 200);
    end
    chk("held shot count", shots, 1);

    // Left edge: 6 -> 2 -> retire.
    fire = 1'b0;
    do_reset();
    tick();
    fire = 1'b1; sx = 10'd6; sy = 10'd50; dir = 2'b01;
    tick(); chk("left X0", bx, 6);
    tick(); chk("left X1", bx, 2);
    tick(); chk("left retire", last, 3); chk("left parked", bx, PARK);

    // Down edge: retire on first evaluation.
    fire = 1'b0;
    do_reset();
    tick();
    fire = 1'b1; sx = 10'd300; sy = 10'd477; dir = 2'b10;
    tick(); chk("down Y0", by, 477);
    tick(); chk("down retire", last, 3); chk("down act", act, 0);

    // Target beats armor and out-of-bounds; late armor in cooldown is ignored.
    fire = 1'b0;
    do_reset();
    tick();
    fire = 1'b1; sx = 10'd638; sy = 10'd100; dir = 2'b00;
    tick();
    th = 1; ah = 1;
    tick(); chk("priority last", last, 1); chk("priority act", act, 0);
    th = 0; ah = 1;
    tick(); chk("stale armor last", last, 1);
    ah = 0;

    // Zero-cooldown build: retire at m, respawn at m+1.
    fire = 1'b0; fire0 = 1'b0;
    do_reset();
    tick();
    fire0 = 1'b1; sx = 10'd200; sy = 10'd200; dir = 2'b11;
    tick(); chk("cd0 spawn", act0, 1); chk("cd0 shot", shot0, 1); chk("cd0 Y", by0, 200);
    fire0 = 1'b0; th0 = 1'b1;
    tick(); chk("cd0 retire act", act0, 0); chk("cd0 last", last0, 1); chk("cd0 park", by0, PARK);
    fire0 = 1'b1; th0 = 1'b0; sx = 10'd10;
    tick(); chk("cd0 respawn", act0, 1); chk("cd0 respawn X", bx0, 10);
    chk("cd0 size", bsz0, SIZE);
    fire0 = 1'b0;

    // Random stimulus against the model, with occasional async resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) fire = ~fire;
      sx  = 10'($urandom_range(0, X_MAX));
      sy  = 10'($urandom_range(0, Y_MAX));
      dir = 2'($urandom);
      th  = ($urandom_range(0, 29) == 0);
      ah  = ($urandom_range(0, 29) == 0);
      bh  = ($urandom_range(0, 29) == 0);
      if (i % 700 == 350) do_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
